// File: rtl/argon_mem_pkg.sv
// Shared definitions for Argon data-memory responders: access-size encodings,
// UART register offsets, transmitter states and read-data extension.
package argon_mem_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_BYTE = 2'b01,
    WR_HALF = 2'b10,
    WR_WORD = 2'b11
  } wr_mask_e;

  typedef enum logic [2:0] {
    RD_NONE   = 3'b000,
    RD_BYTE_U = 3'b001,
    RD_HALF_U = 3'b010,
    RD_WORD   = 3'b011,
    RD_BAD_4  = 3'b100,
    RD_BYTE_S = 3'b101,
    RD_HALF_S = 3'b110,
    RD_BAD_7  = 3'b111
  } rd_mask_e;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_DIVISOR  = 2'd2;
  localparam logic [1:0] REG_RESERVED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [31:0] extend_read(input logic [31:0] data, input logic [2:0] rd_mask);
    logic [31:0] r;
    case (rd_mask)
      RD_BYTE_U: r = {24'd0, data[7:0]};
      RD_HALF_U: r = {16'd0, data[15:0]};
      RD_WORD:   r = data;
      RD_BYTE_S: r = {{24{data[7]}}, data[7:0]};
      RD_HALF_S: r = {{16{data[15]}}, data[15:0]};
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with combinational head read; pushes when full and pops
// when empty are ignored, fullness judged on the pre-edge count.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the Argon data-memory port.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module mmio_uart_tx
  import argon_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [1:0]  i_wr_mask,
  input  logic [2:0]  i_rd_mask,
  output logic [31:0] o_rd_data,
  output logic        o_hit,
  output logic        o_err_address_misaligned,
  output logic        o_err_invalid_read_mask,
  output logic        o_tx,
  output tx_state_e   dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  logic          hit, aligned, half_or_word, wr_en, rd_valid, push;
  logic [1:0]    offset;
  logic [15:0]   divisor;
  logic          overflow;
  logic [31:0]   reg_rdata;
  logic [31:0]   count_wide;
  logic [3:0]    count_sat;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_data;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  tx_state_e   state, state_next;
  logic [15:0] cnt, cnt_next, bit_len_m1;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        tx_bit, busy;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        par, par_next;
`endif

  assign unused_bits = ^i_wr_data[31:16];

  assign hit          = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign offset       = i_addr[3:2];
  assign aligned      = (i_addr[1:0] == 2'b00);
  assign half_or_word = (i_wr_mask == WR_HALF) || (i_wr_mask == WR_WORD) ||
                        (i_rd_mask == RD_HALF_U) || (i_rd_mask == RD_HALF_S) ||
                        (i_rd_mask == RD_WORD);

  assign o_err_address_misaligned = hit && half_or_word && !aligned;
  assign o_err_invalid_read_mask  = hit && ((i_rd_mask == RD_BAD_4) || (i_rd_mask == RD_BAD_7));

  // Unaligned accesses of any size are inert, so alignment gates writes directly.
  assign wr_en    = hit && aligned && (i_wr_mask != WR_NONE) && !o_err_invalid_read_mask;
  assign rd_valid = hit && aligned && (i_rd_mask != RD_NONE) && !o_err_invalid_read_mask;
  assign push     = wr_en && (offset == REG_TXDATA);

  assign busy       = (state != ST_IDLE);
  assign count_wide = 32'(fifo_count);
  assign count_sat  = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

  always_comb begin
    reg_rdata = 32'd0;
    case (offset)
      REG_STATUS:  reg_rdata = {23'd0, PARITY_FLAG, count_sat, overflow, busy, fifo_empty, fifo_full};
      REG_DIVISOR: reg_rdata = {16'd0, divisor};
      default:     reg_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hit     <= 1'b0;
      o_rd_data <= 32'd0;
      divisor   <= DEFAULT_DIVISOR;
      overflow  <= 1'b0;
    end else begin
      o_hit     <= hit;
      o_rd_data <= rd_valid ? extend_read(reg_rdata, i_rd_mask) : 32'd0;
      if (wr_en && (offset == REG_DIVISOR)) begin
        if (i_wr_mask == WR_BYTE) divisor[7:0] <= i_wr_data[7:0];
        else                      divisor      <= i_wr_data[15:0];
      end
      if (push && fifo_full)                                          overflow <= 1'b1;
      else if (wr_en && (offset == REG_STATUS) && i_wr_data[3])       overflow <= 1'b0;
    end
  end

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (push),
    .push_data (i_wr_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Divisor 0 behaves as 1; the bit length is latched at each bit boundary.
  assign bit_len_m1 = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;

  always_comb begin
    state_next   = state;
    cnt_next     = (cnt != 16'd0) ? cnt - 16'd1 : cnt;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    pop          = 1'b0;
    tx_bit       = 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
    par_next     = par;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_data;
          cnt_next   = bit_len_m1;
          state_next = ST_START;
`ifdef MMIO_UART_TX_PARITY_EN
          par_next   = ^fifo_data;
`endif
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (cnt == 16'd0) begin
          state_next   = ST_DATA;
          bit_idx_next = 3'd0;
          cnt_next     = bit_len_m1;
        end
      end
      ST_DATA: begin
        tx_bit = shift[0];
        if (cnt == 16'd0) begin
          cnt_next = bit_len_m1;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            shift_next   = shift >> 1;
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_bit = par;
        if (cnt == 16'd0) begin
          cnt_next   = bit_len_m1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_bit = 1'b1;
        if (cnt == 16'd0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_data;
            cnt_next   = bit_len_m1;
            state_next = ST_START;
`ifdef MMIO_UART_TX_PARITY_EN
            par_next   = ^fifo_data;
`endif
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // o_tx is a registered copy of the current state's line level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      cnt     <= 16'd0;
      shift   <= 8'd0;
      bit_idx <= 3'd0;
      o_tx    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      o_tx    <= tx_bit;
`ifdef MMIO_UART_TX_PARITY_EN
      par     <= par_next;
`endif
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-level reads/writes with literal
// expectations plus a line monitor that checks every frame cycle against a queue.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
  import argon_mem_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] ST_PAR     = 32'h0000_0100;
  localparam logic [31:0] ST_CLR     = 32'h0000_0085;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] ST_PAR     = 32'h0000_0000;
  localparam logic [31:0] ST_CLR     = 32'h0000_0074;
`endif

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_addr, i_wr_data, o_rd_data;
  logic [1:0]  i_wr_mask;
  logic [2:0]  i_rd_mask;
  logic        o_hit, o_err_address_misaligned, o_err_invalid_read_mask, o_tx;
  tx_state_e   dbg_state;

  int        checks = 0;
  int        failures = 0;
  logic [7:0] exp_q[$];
  int        div_model = 868;
  logic      mon_en = 1'b0;
  logic      mon_abort = 1'b0;
  logic      mon_busy = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .i_clk                    (clk),
    .i_reset                  (i_reset),
    .i_addr                   (i_addr),
    .i_wr_data                (i_wr_data),
    .i_wr_mask                (i_wr_mask),
    .i_rd_mask                (i_rd_mask),
    .o_rd_data                (o_rd_data),
    .o_hit                    (o_hit),
    .o_err_address_misaligned (o_err_address_misaligned),
    .o_err_invalid_read_mask  (o_err_invalid_read_mask),
    .o_tx                     (o_tx),
    .dbg_state                (dbg_state)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Line level of bit slot j of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (FRAME_BITS == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  // driver tasks
  task automatic bus_idle();
    i_addr    = 32'd0;
    i_wr_data = 32'd0;
    i_wr_mask = 2'b00;
    i_rd_mask = 3'b000;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    @(negedge clk);
    i_addr = a; i_wr_data = d; i_wr_mask = m; i_rd_mask = 3'b000;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [2:0] m,
                          input logic [31:0] exp, input logic exp_hit);
    @(negedge clk);
    i_addr = a; i_wr_data = 32'd0; i_wr_mask = 2'b00; i_rd_mask = m;
    @(posedge clk); #1;
    bus_idle();
    check1({name, "_hit"}, o_hit, exp_hit);
    check32(name, o_rd_data, exp);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check1({name, "_drain"}, (exp_q.size() == 0) && !mon_busy, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  // scoreboard: every cycle of every frame is compared against the queued byte
  initial begin : monitor
    logic [7:0] b;
    int d;
    int idle_wait;
    idle_wait = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !mon_abort) begin
        if (o_tx === 1'b0) begin
          d = (div_model < 1) ? 1 : div_model;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start: o_tx low with no byte queued");
            repeat (FRAME_BITS * d - 1) @(negedge clk);
          end else begin
            b = exp_q.pop_front();
            mon_busy = 1'b1;
            for (int k = 0; k < FRAME_BITS * d; k++) begin
              if (k > 0) @(negedge clk);
              if (mon_abort) break;
              check1("frame_bit", o_tx, frame_bit(b, k / d));
            end
            mon_busy = 1'b0;
          end
          idle_wait = 0;
        end else if (exp_q.size() != 0) begin
          idle_wait++;
          if (idle_wait > 200) begin
            checks++;
            failures++;
            $display("FAIL start_timeout: queued byte %h never started", exp_q[0]);
            exp_q.delete();
            idle_wait = 0;
          end
        end else begin
          idle_wait = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic [8:0] a5_line;
    int n;
    a5_line = 9'b10100101_0;
    bus_idle();
    i_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check1("rst_tx", o_tx, 1'b1);
    check1("rst_hit", o_hit, 1'b0);
    check32("rst_rd_data", o_rd_data, 32'd0);
    check32("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    mon_en = 1'b1;

    bus_read("status_reset", BASE + 32'h4, 3'b011, 32'h0000_0002 | ST_PAR, 1'b1);
    bus_read("divisor_reset", BASE + 32'h8, 3'b011, 32'h0000_0364, 1'b1);
    bus_read("txdata_read", BASE, 3'b011, 32'd0, 1'b1);
    bus_read("miss_read", 32'h0000_0004, 3'b011, 32'd0, 1'b0);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 2'b11);
    bus_read("reserved_read", BASE + 32'hC, 3'b011, 32'd0, 1'b1);

    // 0xA5 at four cycles per bit; upper write-data bits must be ignored
    bus_write(BASE + 32'h8, 32'd4, 2'b11);
    div_model = 4;
    bus_read("divisor_4", BASE + 32'h8, 3'b011, 32'd4, 1'b1);
    exp_q.push_back(8'hA5);
    bus_write(BASE, 32'h0000_01A5, 2'b01);
    @(negedge clk);
    check1("a5_after_push", o_tx, 1'b1);
    @(negedge clk);
    check1("a5_after_pop", o_tx, 1'b1);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      check1("a5_line", o_tx, a5_line[k / 4]);
    end
    wait_drain("a5", 200);

    // Burst at one cycle per bit: the first byte leaves the FIFO one edge
    // after its write, so eight more fill it and the tenth write overflows.
    bus_write(BASE + 32'h8, 32'd1, 2'b11);
    div_model = 1;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(8'h30 + i));
      bus_write(BASE, 32'(8'h30 + i), 2'b01);
    end
    bus_read("status_overflow", BASE + 32'h4, 3'b011, 32'h0000_008D | ST_PAR, 1'b1);
    bus_write(BASE + 32'h4, 32'h0000_0008, 2'b11);
    bus_read("status_ovf_clear", BASE + 32'h4, 3'b011, ST_CLR | ST_PAR, 1'b1);
    wait_drain("burst", 400);
    bus_read("status_drained", BASE + 32'h4, 3'b011, 32'h0000_0002 | ST_PAR, 1'b1);

    // error flags and write suppression
    @(negedge clk);
    i_addr = BASE + 32'h6; i_wr_data = 32'h0000_1234; i_wr_mask = 2'b10;
    #1;
    check1("misaligned_flag", o_err_address_misaligned, 1'b1);
    check1("misaligned_no_rdmask_err", o_err_invalid_read_mask, 1'b0);
    @(posedge clk); #1 bus_idle();
    bus_read("divisor_after_misaligned", BASE + 32'h8, 3'b011, 32'd1, 1'b1);
    @(negedge clk);
    i_addr = BASE + 32'h4; i_rd_mask = 3'b111;
    #1;
    check1("invalid_rdmask_flag", o_err_invalid_read_mask, 1'b1);
    check1("invalid_rdmask_no_misalign", o_err_address_misaligned, 1'b0);
    @(posedge clk); #1 bus_idle();
    check1("invalid_rdmask_hit", o_hit, 1'b1);
    check32("invalid_rdmask_data", o_rd_data, 32'd0);
    @(negedge clk);
    i_addr = 32'h0000_0006; i_wr_mask = 2'b10;
    #1;
    check1("miss_no_misaligned", o_err_address_misaligned, 1'b0);
    @(posedge clk); #1 bus_idle();
    bus_write(BASE + 32'h1, 32'h0000_0055, 2'b01);
    bus_read("unaligned_byte_read", BASE + 32'h9, 3'b001, 32'd0, 1'b1);

    // DIVISOR extension and byte-lane writes
    bus_write(BASE + 32'h8, 32'h0000_80F0, 2'b11);
    bus_read("div_half_sext", BASE + 32'h8, 3'b110, 32'hFFFF_80F0, 1'b1);
    bus_read("div_byte_zext", BASE + 32'h8, 3'b001, 32'h0000_00F0, 1'b1);
    bus_read("div_byte_sext", BASE + 32'h8, 3'b101, 32'hFFFF_FFF0, 1'b1);
    bus_write(BASE + 32'h8, 32'hAAAA_AA12, 2'b01);
    bus_read("div_byte_write", BASE + 32'h8, 3'b010, 32'h0000_8012, 1'b1);

    // reset in the middle of the third data bit
    bus_write(BASE + 32'h8, 32'd2, 2'b11);
    div_model = 2;
    exp_q.push_back(8'h3C);
    bus_write(BASE, 32'h0000_003C, 2'b01);
    n = 0;
    while (o_tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check1("reset_frame_started", o_tx, 1'b0);
    repeat (6) @(negedge clk);
    mon_abort = 1'b1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    exp_q.delete();
    div_model = 868;
    check1("reset_tx_high", o_tx, 1'b1);
    check32("reset_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    bus_read("reset_status", BASE + 32'h4, 3'b011, 32'h0000_0002 | ST_PAR, 1'b1);
    bus_read("reset_divisor", BASE + 32'h8, 3'b011, 32'h0000_0364, 1'b1);
    mon_abort = 1'b0;
    repeat (60) @(negedge clk);
    check1("idle_after_reset", o_tx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
